mul8_nibble_seq: RTL and testbench

Sequential 8x8 unsigned multiplier controller that feeds and consumes the team's combinational 4x4 array multiplier. It sits directly upstream and downstream of that multiplier: it accepts an 8-bit operand pair over a valid/ready handshake and drives nibble pairs onto the multiplier's Q/M inputs. It also shift-accumulates the returned 8-bit partial products and presents the 16-bit product over a valid/ready handshake.

---
 rtl/mul8_nibble_seq.sv | 166 ++++++++++++++++
 tb/tb_mul8_nibble_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_nibble_seq.sv
// mul8_nibble_seq
// ---------------------------------------------------------------------------
// Sequential 8x8 unsigned multiplier controller. An operand pair is taken in
// over a valid/ready handshake, split into nibbles and fed pairwise to an
// external combinational 4x4 multiplier (q_o/m_o -> p_i). The returned
// partial products are shift-accumulated and the 16-bit product is offered
// downstream over a second valid/ready handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer keeps valid and data stable until that edge;
// ready may depend combinationally on the other side's ready (in_ready
// follows out_ready while a result is waiting) but never on valid.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous reset, active low
//   in_valid   operand pair valid          in_ready   can accept a pair
//   a_i, b_i   8-bit multiplicand / multiplier
//   q_o, m_o   nibble pair to the external 4x4 multiplier
//   p_i        8-bit product returned by the external multiplier
//   out_valid  result valid                out_ready  downstream accepts
//   result_o   16-bit unsigned a*b
//   busy       high while multiplying
//
// REG_PROD = 1 registers p_i (and its shift) before it is accumulated, which
// cuts the path through the external multiplier at the cost of one cycle.
// ---------------------------------------------------------------------------
module mul8_nibble_seq #(
    parameter int REG_PROD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [3:0]  q_o,
    output logic [3:0]  m_o,
    input  logic [7:0]  p_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result_o,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // With a registered product the accumulation trails by one step, so an
    // extra accumulate-only step (step 4) is needed.
    localparam logic [2:0] LAST_STEP = (REG_PROD != 0) ? 3'd4 : 3'd3;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  pp_q, pp_d;
    logic [3:0]  sh_q, sh_d;

    logic        accept;
    logic        zero_op;
    logic        nib_active;
    logic [3:0]  q_sel;
    logic [3:0]  m_sel;
    logic [3:0]  cur_shift;
    logic [15:0] add_term;

    assign accept  = in_valid & in_ready;
    assign zero_op = (a_i == 8'd0) || (b_i == 8'd0);

    // Step decode: step[0] picks the high nibble of a, step[1] the high
    // nibble of b; the shift is the sum of the two nibble weights.
    always_comb begin
        nib_active = (state_q == ST_MUL) && (step_q < 3'd4);
        q_sel      = step_q[0] ? a_q[7:4] : a_q[3:0];
        m_sel      = step_q[1] ? b_q[7:4] : b_q[3:0];
        cur_shift  = 4'd0;
        case (step_q)
            3'd1, 3'd2: cur_shift = 4'd4;
            3'd3:       cur_shift = 4'd8;
            default:    cur_shift = 4'd0;
        endcase
        if (REG_PROD != 0) begin
            add_term = {8'd0, pp_q} << sh_q;
        end else begin
            add_term = {8'd0, p_i} << cur_shift;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            acc_q   <= 16'd0;
            step_q  <= 3'd0;
            pp_q    <= 8'd0;
            sh_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            pp_q    <= pp_d;
            sh_q    <= sh_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        pp_d    = pp_q;
        sh_d    = sh_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    // A zero operand skips the multiply; acc=0 is the answer.
                    a_d     = a_i;
                    b_d     = b_i;
                    acc_d   = 16'd0;
                    step_d  = 3'd0;
                    pp_d    = 8'd0;
                    sh_d    = 4'd0;
                    state_d = zero_op ? ST_DONE : ST_MUL;
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d  = acc_q + add_term;
                step_d = step_q + 3'd1;
                // pp stays 0 on the accumulate-only step so nothing is
                // counted twice.
                pp_d   = nib_active ? p_i : 8'd0;
                sh_d   = cur_shift;
                if (step_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_MUL);
        q_o       = nib_active ? q_sel : 4'd0;
        m_o       = nib_active ? m_sel : 4'd0;
        result_o  = acc_q;
    end

endmodule

// File: tb/tb_mul8_nibble_seq.sv
// Bench for mul8_nibble_seq: one instance per REG_PROD setting, each with a
// behavioural 4x4 multiplier stub on p_i. Expected nibble sequences, latency
// and products come from a plain-arithmetic model of the multiply.
module tb_mul8_nibble_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv0, ir0, ov0, or0, busy0;
    logic [7:0]  a0, b0, p0;
    logic [3:0]  q0, m0;
    logic [15:0] r0;

    logic        iv1, ir1, ov1, or1, busy1;
    logic [7:0]  a1, b1, p1;
    logic [3:0]  q1, m1;
    logic [15:0] r1;

    assign p0 = {4'd0, q0} * {4'd0, m0};
    assign p1 = {4'd0, q1} * {4'd0, m1};

    mul8_nibble_seq #(.REG_PROD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .a_i(a0), .b_i(b0), .q_o(q0), .m_o(m0), .p_i(p0),
        .out_valid(ov0), .out_ready(or0), .result_o(r0), .busy(busy0)
    );

    mul8_nibble_seq #(.REG_PROD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a_i(a1), .b_i(b1), .q_o(q1), .m_o(m1), .p_i(p1),
        .out_valid(ov1), .out_ready(or1), .result_o(r1), .busy(busy1)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] tab_a [3] = '{8'hFF, 8'h12, 8'h00};
    logic [7:0] tab_b [3] = '{8'hFF, 8'h34, 8'h7F};

    // Nibble pair expected on q/m in multiply step s (0..3).
    function automatic logic [7:0] qm_ref(input logic [7:0] a, input logic [7:0] b, input int s);
        logic [3:0] q, m;
        q = (s == 1 || s == 3) ? a[7:4] : a[3:0];
        m = (s >= 2) ? b[7:4] : b[3:0];
        return {q, m};
    endfunction

    function automatic logic [15:0] prod_ref(input logic [7:0] a, input logic [7:0] b);
        return 16'(a) * 16'(b);
    endfunction

    function automatic logic [7:0] rand_opnd();
        return ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
    endfunction

    task automatic test_reset();
        logic [26:0] exp_s;
        exp_s = {1'b0, 1'b1, 1'b0, 8'h00, 16'h0000};
        @(negedge clk);
        vectors++;
        if ({ov0, ir0, busy0, q0, m0, r0} !== exp_s) begin
            miscompares++;
            $display("FAIL reset0 got %h want %h", {ov0, ir0, busy0, q0, m0, r0}, exp_s);
        end
        vectors++;
        if ({ov1, ir1, busy1, q1, m1, r1} !== exp_s) begin
            miscompares++;
            $display("FAIL reset1 got %h want %h", {ov1, ir1, busy1, q1, m1, r1}, exp_s);
        end
    endtask

    // Operand pairs streamed back to back on dut0 with out_ready=1; the next
    // pair is accepted on the same edge that hands off the previous result.
    task automatic test_ops(input int n, input bit fixed);
        logic [7:0]  a, b;
        logic [10:0] exp_s, got_s;
        int lat, busy_n;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (fixed) begin
                a = tab_a[i];
                b = tab_b[i];
            end else begin
                a = rand_opnd();
                b = rand_opnd();
            end
            iv0 = 1'b1; a0 = a; b0 = b; or0 = 1'b1;
            @(posedge clk);
            #1;
            iv0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom);
            lat    = (a == 8'd0 || b == 8'd0) ? 1 : 5;
            busy_n = 0;
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                busy_n += int'(busy0);
                if (k < lat) exp_s = {1'b0, 1'b0, 1'b1, qm_ref(a, b, k - 1)};
                else         exp_s = {1'b1, 1'b1, 1'b0, 8'h00};
                got_s = {ov0, ir0, busy0, q0, m0};
                vectors++;
                if (got_s !== exp_s) begin
                    miscompares++;
                    $display("FAIL ops %h*%h cyc%0d ctrl got %h want %h", a, b, k, got_s, exp_s);
                end
            end
            vectors++;
            if (r0 !== prod_ref(a, b)) begin
                miscompares++;
                $display("FAIL ops %h*%h result got %h want %h", a, b, r0, prod_ref(a, b));
            end
            vectors++;
            if (busy_n !== ((lat == 1) ? 0 : 4)) begin
                miscompares++;
                $display("FAIL ops %h*%h busy cycles got %0d want %0d", a, b, busy_n, (lat == 1) ? 0 : 4);
            end
        end
        @(negedge clk);
        vectors++;
        if ({ov0, ir0} !== 2'b01) begin
            miscompares++;
            $display("FAIL ops drain ov/ir got %b want 01", {ov0, ir0});
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        iv0 = 1'b1; a0 = 8'h12; b0 = 8'h34; or0 = 1'b0;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        repeat (4) @(negedge clk);
        for (int h = 0; h < 10; h++) begin
            @(negedge clk);
            vectors++;
            if ({ov0, ir0, r0} !== {1'b1, 1'b0, 16'h03A8}) begin
                miscompares++;
                $display("FAIL hold%0d ov/ir/result got %h want %h", h, {ov0, ir0, r0}, {1'b1, 1'b0, 16'h03A8});
            end
        end
        // Release the result and present the next pair on the same edge.
        or0 = 1'b1; iv0 = 1'b1; a0 = 8'h0A; b0 = 8'h0B;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ov0, busy0, q0, m0} !== {1'b0, 1'b1, 4'hA, 4'hB}) begin
            miscompares++;
            $display("FAIL handoff ov/busy/q/m got %h want %h", {ov0, busy0, q0, m0}, {1'b0, 1'b1, 4'hA, 4'hB});
        end
        repeat (4) @(negedge clk);
        vectors++;
        if ({ov0, r0} !== {1'b1, 16'h006E}) begin
            miscompares++;
            $display("FAIL handoff result got %h want %h", {ov0, r0}, {1'b1, 16'h006E});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        iv0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF; or0 = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy0, q0, m0} !== {1'b1, 4'hF, 4'hF}) begin
            miscompares++;
            $display("FAIL midrst step2 got %h want %h", {busy0, q0, m0}, {1'b1, 4'hF, 4'hF});
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ov0, ir0, busy0, q0, m0, r0} !== {1'b0, 1'b1, 1'b0, 8'h00, 16'h0000}) begin
            miscompares++;
            $display("FAIL midrst after got %h want %h", {ov0, ir0, busy0, q0, m0, r0},
                     {1'b0, 1'b1, 1'b0, 8'h00, 16'h0000});
        end
        iv0 = 1'b1; a0 = 8'h03; b0 = 8'h05;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if ({ov0, r0} !== {1'b1, 16'h000F}) begin
            miscompares++;
            $display("FAIL midrst 3*5 got %h want %h", {ov0, r0}, {1'b1, 16'h000F});
        end
        @(posedge clk);
        #1;
    endtask

    // dut1: first pair 0xFF*0xFF, then random pairs, back to back.
    task automatic test_regprod(input int n);
        logic [7:0]  a, b;
        logic [10:0] exp_s, got_s;
        int lat, busy_n;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            a = (i == 0) ? 8'hFF : rand_opnd();
            b = (i == 0) ? 8'hFF : rand_opnd();
            iv1 = 1'b1; a1 = a; b1 = b; or1 = 1'b1;
            @(posedge clk);
            #1;
            iv1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
            lat    = (a == 8'd0 || b == 8'd0) ? 1 : 6;
            busy_n = 0;
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                busy_n += int'(busy1);
                if (k == lat)    exp_s = {1'b1, 1'b1, 1'b0, 8'h00};
                else if (k == 5) exp_s = {1'b0, 1'b0, 1'b1, 8'h00};
                else             exp_s = {1'b0, 1'b0, 1'b1, qm_ref(a, b, k - 1)};
                got_s = {ov1, ir1, busy1, q1, m1};
                vectors++;
                if (got_s !== exp_s) begin
                    miscompares++;
                    $display("FAIL regprod %h*%h cyc%0d ctrl got %h want %h", a, b, k, got_s, exp_s);
                end
            end
            vectors++;
            if (r1 !== prod_ref(a, b)) begin
                miscompares++;
                $display("FAIL regprod %h*%h result got %h want %h", a, b, r1, prod_ref(a, b));
            end
            vectors++;
            if (busy_n !== ((lat == 1) ? 0 : 5)) begin
                miscompares++;
                $display("FAIL regprod %h*%h busy cycles got %0d want %0d", a, b, busy_n, (lat == 1) ? 0 : 5);
            end
        end
        @(negedge clk);
        vectors++;
        if ({ov1, ir1} !== 2'b01) begin
            miscompares++;
            $display("FAIL regprod drain ov/ir got %b want 01", {ov1, ir1});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv0 = 1'b0; a0 = 8'd0; b0 = 8'd0; or0 = 1'b0;
        iv1 = 1'b0; a1 = 8'd0; b1 = 8'd0; or1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_ops(3, 1'b1);
        test_backpressure();
        test_reset_mid();
        test_ops(100, 1'b0);
        test_regprod(257);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
